// File: rtl/cv32e40p_compressed_decoder_voter_if.sv
// Handshake bundle between the triplicated compressed decoders, the voter and the ID stage.
// slave is the voter's view; master is the surrounding pipeline's view.
interface cv32e40p_compressed_decoder_voter_if #(
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     valid_i;
    logic                     ready_o;
    logic [31:0]              instr_i_1;
    logic [31:0]              instr_i_2;
    logic [31:0]              instr_i_3;
    logic                     is_compressed_i_1;
    logic                     is_compressed_i_2;
    logic                     is_compressed_i_3;
    logic                     illegal_instr_i_1;
    logic                     illegal_instr_i_2;
    logic                     illegal_instr_i_3;
    logic                     flush_i;
    logic                     clear_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [31:0]              instr_o;
    logic                     is_compressed_o;
    logic                     illegal_instr_o;
    logic                     corrected_o;
    logic                     uncorrectable_o;
    logic [2:0]               lane_fault_o;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_o;

    modport slave (
        input  valid_i, instr_i_1, instr_i_2, instr_i_3,
               is_compressed_i_1, is_compressed_i_2, is_compressed_i_3,
               illegal_instr_i_1, illegal_instr_i_2, illegal_instr_i_3,
               flush_i, clear_i, ready_i,
        output ready_o, valid_o, instr_o, is_compressed_o, illegal_instr_o,
               corrected_o, uncorrectable_o, lane_fault_o, err_cnt_o
    );

    modport master (
        output valid_i, instr_i_1, instr_i_2, instr_i_3,
               is_compressed_i_1, is_compressed_i_2, is_compressed_i_3,
               illegal_instr_i_1, illegal_instr_i_2, illegal_instr_i_3,
               flush_i, clear_i, ready_i,
        input  ready_o, valid_o, instr_o, is_compressed_o, illegal_instr_o,
               corrected_o, uncorrectable_o, lane_fault_o, err_cnt_o
    );
endinterface

// File: rtl/cv32e40p_compressed_decoder_voter.sv
// Registered bitwise majority voter for the triplicated compressed decoder, with
// persistent-fault lane masking and forced-illegal output when no safe majority exists.
module cv32e40p_compressed_decoder_voter #(
    parameter int PERSIST_THRESH = 3,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
    cv32e40p_compressed_decoder_voter_if.slave bus
);
    localparam int BW = 34;

    logic [BW-1:0] lane_w [3];
    logic [BW-1:0] maj_w;
    logic [BW-1:0] vote_w;
    logic [BW-1:0] cap_w;
    logic          eq01, eq02, eq12;
    logic          three_healthy;
    logic          uncorr;
    logic [2:0]    diss;
    logic [2:0]    sole;
    logic          corrected;
    logic          accept;
    logic          count_en;

    logic                     valid_reg;
    logic [BW-1:0]            word_reg;
    logic                     corrected_reg;
    logic                     uncorr_reg;
    logic [2:0]               lane_fault_reg;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;
    logic [3:0]               cnt_reg [3];

    assign lane_w[0] = {bus.illegal_instr_i_1, bus.is_compressed_i_1, bus.instr_i_1};
    assign lane_w[1] = {bus.illegal_instr_i_2, bus.is_compressed_i_2, bus.instr_i_2};
    assign lane_w[2] = {bus.illegal_instr_i_3, bus.is_compressed_i_3, bus.instr_i_3};

    assign maj_w = (lane_w[0] & lane_w[1]) | (lane_w[0] & lane_w[2]) | (lane_w[1] & lane_w[2]);
    assign eq01  = (lane_w[0] == lane_w[1]);
    assign eq02  = (lane_w[0] == lane_w[2]);
    assign eq12  = (lane_w[1] == lane_w[2]);

    // With a lane masked, the lower-numbered healthy lane is the reference copy.
    always_comb begin
        vote_w        = maj_w;
        uncorr        = 1'b1;
        three_healthy = 1'b0;
        case (~lane_fault_reg)
            3'b111: begin
                three_healthy = 1'b1;
                uncorr        = !(eq01 || eq02 || eq12);
            end
            3'b011: begin
                vote_w = lane_w[0];
                uncorr = !eq01;
            end
            3'b101: begin
                vote_w = lane_w[0];
                uncorr = !eq02;
            end
            3'b110: begin
                vote_w = lane_w[1];
                uncorr = !eq12;
            end
            default: begin
                vote_w = maj_w;
                uncorr = 1'b1;
            end
        endcase
    end

    assign cap_w     = uncorr ? {1'b1, vote_w[BW-2:0]} : vote_w;
    assign corrected = |diss;
    assign accept    = bus.valid_i && bus.ready_o && !bus.flush_i;
    assign count_en  = accept && !bus.clear_i;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign diss[gi] = three_healthy && !uncorr && (lane_w[gi] != maj_w);
            assign sole[gi] = diss[gi] && ((diss & ~(3'b001 << gi)) == 3'b000);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi]        <= 4'd0;
                    lane_fault_reg[gi] <= 1'b0;
                end else if (bus.clear_i) begin
                    cnt_reg[gi]        <= 4'd0;
                    lane_fault_reg[gi] <= 1'b0;
                end else if (count_en && three_healthy) begin
                    cnt_reg[gi] <= sole[gi] ? cnt_reg[gi] + 4'd1 : 4'd0;
                    if (sole[gi] && (cnt_reg[gi] == 4'(PERSIST_THRESH - 1)))
                        lane_fault_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (bus.clear_i) begin
            err_cnt_reg <= '0;
        end else if (count_en && (corrected || uncorr) && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    // Output register: flush wins over accept; a consumed word without a reload empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg     <= 1'b0;
            word_reg      <= '0;
            corrected_reg <= 1'b0;
            uncorr_reg    <= 1'b0;
        end else if (bus.flush_i) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg     <= 1'b1;
            word_reg      <= cap_w;
            corrected_reg <= corrected;
            uncorr_reg    <= uncorr;
        end else if (bus.ready_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.ready_o         = !valid_reg || bus.ready_i;
    assign bus.valid_o         = valid_reg;
    assign bus.instr_o         = word_reg[31:0];
    assign bus.is_compressed_o = word_reg[32];
    assign bus.illegal_instr_o = word_reg[33];
    assign bus.corrected_o     = corrected_reg;
    assign bus.uncorrectable_o = uncorr_reg;
    assign bus.lane_fault_o    = lane_fault_reg;
    assign bus.err_cnt_o       = err_cnt_reg;
endmodule
